// File: rtl/adc128s_spi_resp.sv
// SPI responder for the ADC128S-style two-frame protocol: returns the sample of the channel named in the previous frame.
// Build option: define ADC_MISO_TRI_EN to float MISO while idle (shared MISO line); otherwise MISO drives 0 when idle.
module adc128s_spi_resp #(
    parameter int NUM_CH = 8,
    parameter int RES_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    SCLK,
    input  logic                    MOSI,
    output logic                    MISO,
    input  logic [NUM_CH*RES_W-1:0] ana_ch,
    output logic [2:0]              chnl,
    output logic                    cmd_vld,
    output logic                    frm_err
);

    // state | meaning
    // IDLE  | slave not selected, waiting for SS_n fall
    // LOAD  | one clk: freeze the selected sample into tx_shft
    // SHIFT | counting SCLK rises, shifting MOSI in and MISO out
    // DONE  | 16 bits seen, waiting for SS_n rise to commit
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [4:0]       bit_cnt;
    logic [15:0]      tx_shft;
    // Only the last 14 bits of the command are ever needed; [13:11] is the channel.
    logic [13:0]      rx_shft;
    logic [RES_W-1:0] sample;

    logic ss_ff1, ss_ff2, ss_ff3;
    logic sclk_ff1, sclk_ff2, sclk_ff3;
    logic mosi_ff1, mosi_ff2;
    logic ss_rise, ss_fall, sclk_rise, sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff1   <= 1'b1;
            ss_ff2   <= 1'b1;
            ss_ff3   <= 1'b1;
            sclk_ff1 <= 1'b0;
            sclk_ff2 <= 1'b0;
            sclk_ff3 <= 1'b0;
            mosi_ff1 <= 1'b0;
            mosi_ff2 <= 1'b0;
        end else begin
            ss_ff1   <= SS_n;
            ss_ff2   <= ss_ff1;
            ss_ff3   <= ss_ff2;
            sclk_ff1 <= SCLK;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            mosi_ff1 <= MOSI;
            mosi_ff2 <= mosi_ff1;
        end
    end

    assign ss_rise   =  ss_ff2 & ~ss_ff3;
    assign ss_fall   = ~ss_ff2 &  ss_ff3;
    assign sclk_rise =  sclk_ff2 & ~sclk_ff3;
    assign sclk_fall = ~sclk_ff2 &  sclk_ff3;

    // Channels beyond NUM_CH read as zero.
    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chnl == 3'(k)) sample = ana_ch[k*RES_W +: RES_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_shft <= '0;
            rx_shft <= '0;
            chnl    <= '0;
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) state <= LOAD;
                end
                LOAD: begin
                    tx_shft <= {{(16-RES_W){1'b0}}, sample};
                    bit_cnt <= '0;
                    rx_shft <= '0;
                    if (ss_rise) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shft <= {rx_shft[12:0], mosi_ff2};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) state <= DONE;
                    end else if (sclk_fall && bit_cnt != 5'd0) begin
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end
                end
                DONE: begin
                    if (ss_rise) begin
                        chnl    <= rx_shft[13:11];
                        cmd_vld <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_MISO_TRI_EN
    assign MISO = (state == IDLE) ? 1'bz : tx_shft[15];
`else
    assign MISO = (state == IDLE) ? 1'b0 : tx_shft[15];
`endif

endmodule

// File: tb/tb_adc128s_spi_resp.sv
// Directed bench for adc128s_spi_resp: drives master frames and checks MISO words, chnl, and pulses.
module tb_adc128s_spi_resp;
    localparam int NUM_CH = 6;
    localparam int RES_W  = 12;
    localparam int HALF   = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    SS_n = 1'b1;
    logic                    SCLK = 1'b0;
    logic                    MOSI = 1'b0;
    logic                    MISO;
    logic [NUM_CH*RES_W-1:0] ana_ch = '0;
    logic [2:0]              chnl;
    logic                    cmd_vld;
    logic                    frm_err;

    int n_cmp = 0;
    int n_err = 0;
    int cmd_cnt = 0;
    int err_cnt = 0;
    int lat;
    logic [2:0]  chnl_p;
    logic [15:0] w;
    logic        idle_miso;

    adc128s_spi_resp #(.NUM_CH(NUM_CH), .RES_W(RES_W)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ana_ch(ana_ch), .chnl(chnl), .cmd_vld(cmd_vld), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_vld) cmd_cnt++;
        if (frm_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One master frame: idle level of SCLK selects mode 0 (low) or mode 3 (high).
    task automatic frame(input logic [15:0] mosi_w, input int n_bits, input bit idle_hi,
                         input bit mod_ch1, input bit end_frame, output logic [15:0] miso_w);
        miso_w = '0;
        lat    = 0;
        chnl_p = 3'h0;
        @(negedge clk);
        SCLK = idle_hi;
        repeat (2) @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n_bits; i++) begin
            SCLK = 1'b0;
            MOSI = mosi_w[15-i];
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            miso_w[15-i] = MISO;
            if (mod_ch1 && i == 0) ana_ch[1*RES_W +: RES_W] = 12'hFFF;
            repeat (HALF) @(negedge clk);
        end
        if (end_frame) begin
            SCLK = idle_hi;
            repeat (HALF) @(negedge clk);
            SS_n = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (cmd_vld || frm_err) begin
                    lat    = k;
                    chnl_p = chnl;
                    break;
                end
            end
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
`ifdef ADC_MISO_TRI_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif
        ana_ch[0*RES_W +: RES_W] = 12'h0E7;
        ana_ch[1*RES_W +: RES_W] = 12'h005;
        ana_ch[2*RES_W +: RES_W] = 12'h123;
        ana_ch[3*RES_W +: RES_W] = 12'hABC;
        ana_ch[4*RES_W +: RES_W] = 12'h456;
        ana_ch[5*RES_W +: RES_W] = 12'h5A5;

        // Reset held while the bus toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            SCLK = ~SCLK;
            if (i == 1) SS_n = 1'b0;
            if (i == 4) SS_n = 1'b1;
            MOSI = ~MOSI;
        end
        repeat (4) @(negedge clk);
        check("rst_miso", {15'h0, MISO}, {15'h0, idle_miso});
        check("rst_chnl", {13'h0, chnl}, 16'h0000);
        check("rst_pulses", 16'(cmd_cnt + err_cnt), 16'd0);
        SCLK = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_pulses", 16'(cmd_cnt + err_cnt), 16'd0);

        frame(16'h1800, 16, 1'b0, 1'b0, 1'b1, w);
        check("f1_miso", w, 16'h00E7);
        check("f1_chnl", {13'h0, chnl}, 16'h0003);
        check("f1_cmd_cnt", 16'(cmd_cnt), 16'd1);
        check("f1_lat_ok", {15'h0, (lat >= 1 && lat <= 4)}, 16'h0001);
        check("f1_chnl_at_pulse", {13'h0, chnl_p}, 16'h0003);
        check("idle_miso", {15'h0, MISO}, {15'h0, idle_miso});

        frame(16'h1800, 16, 1'b0, 1'b0, 1'b1, w);
        check("f2_miso", w, 16'h0ABC);
        check("f2_cmd_cnt", 16'(cmd_cnt), 16'd2);

        frame(16'h0800, 9, 1'b0, 1'b0, 1'b1, w);
        check("f3_partial_miso", w, 16'h0A80);
        check("f3_err_cnt", 16'(err_cnt), 16'd1);
        check("f3_cmd_cnt", 16'(cmd_cnt), 16'd2);
        check("f3_chnl_kept", {13'h0, chnl}, 16'h0003);

        frame(16'h0800, 16, 1'b0, 1'b0, 1'b1, w);
        check("f4_miso", w, 16'h0ABC);
        check("f4_chnl", {13'h0, chnl}, 16'h0001);

        frame(16'h0800, 16, 1'b0, 1'b1, 1'b1, w);
        check("f5_frozen_miso", w, 16'h0005);
        check("f5_cmd_cnt", 16'(cmd_cnt), 16'd4);

        frame(16'h2800, 16, 1'b1, 1'b0, 1'b1, w);
        check("f6_idle_hi_miso", w, 16'h0FFF);
        check("f6_chnl", {13'h0, chnl}, 16'h0005);

        frame(16'h3800, 16, 1'b0, 1'b0, 1'b1, w);
        check("f7_ch5_miso", w, 16'h05A5);
        check("f7_chnl", {13'h0, chnl}, 16'h0007);

        frame(16'h2000, 16, 1'b0, 1'b0, 1'b1, w);
        check("f8_ch7_out_of_range", w, 16'h0000);
        check("f8_chnl", {13'h0, chnl}, 16'h0004);

        frame(16'h0000, 16, 1'b0, 1'b0, 1'b1, w);
        check("f9_ch4_miso", w, 16'h0456);
        check("f9_cmd_cnt", 16'(cmd_cnt), 16'd8);
        check("f9_err_cnt", 16'(err_cnt), 16'd1);

        // Reset pulsed after six bits of a frame; master releases the bus while reset is low.
        frame(16'h1800, 6, 1'b0, 1'b0, 1'b0, w);
        check("f10_partial_miso", w, 16'h0000);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", {15'h0, MISO}, {15'h0, idle_miso});
        check("midrst_chnl", {13'h0, chnl}, 16'h0000);
        SS_n = 1'b1;
        SCLK = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_cmd_cnt", 16'(cmd_cnt), 16'd8);
        check("midrst_err_cnt", 16'(err_cnt), 16'd1);
        check("midrst_chnl_after", {13'h0, chnl}, 16'h0000);

        frame(16'h0800, 16, 1'b0, 1'b0, 1'b1, w);
        check("f11_miso", w, 16'h00E7);
        check("f11_chnl", {13'h0, chnl}, 16'h0001);
        check("f11_cmd_cnt", 16'(cmd_cnt), 16'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
